// File: rtl/bcd_counter_pkg.sv
// Shared types, constants and digit arithmetic for the cascaded BCD counter.
// The down-counting helper is only built when COUNTER_UPDOWN_EN is defined.
package bcd_counter_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX    = 4'd9;
   localparam bcd_digit_t BCD_MIN    = 4'd0;
   localparam bcd_digit_t DIV_HALF   = 4'd5;
   localparam int         MAX_DIGITS = 8;

   // Non-decimal nibbles collapse to zero so a bad preset cannot wedge a digit
   function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
      return (d > BCD_MAX) ? BCD_MIN : d;
   endfunction

   function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
      return (d >= BCD_MAX) ? BCD_MIN : bcd_digit_t'(d + 4'd1);
   endfunction

`ifdef COUNTER_UPDOWN_EN
   function automatic bcd_digit_t bcd_dec(input bcd_digit_t d);
      return (d == BCD_MIN || d > BCD_MAX) ? BCD_MAX : bcd_digit_t'(d - 4'd1);
   endfunction
`endif

endpackage

// File: rtl/bcd_digit.sv
// One decade cell of the BCD counter chain. Load has priority over step.
// at_terminal flags the value that makes the next stage advance
// (9 counting up, 0 counting down). The up input and all down logic exist
// only when COUNTER_UPDOWN_EN is defined.
module bcd_digit
   import bcd_counter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       step,
`ifdef COUNTER_UPDOWN_EN
   input  logic       up,
`endif
   input  logic       load,
   input  logic [3:0] load_digit,
   output logic [3:0] digit,
   output logic       at_terminal
);

   bcd_digit_t digit_reg;
   bcd_digit_t digit_next;

   // Next digit value: preset, one step in the selected direction, or hold
   always_comb begin
      digit_next = digit_reg;
      if (load) begin
         digit_next = bcd_sanitize(load_digit);
      end else if (step) begin
`ifdef COUNTER_UPDOWN_EN
         digit_next = up ? bcd_inc(digit_reg) : bcd_dec(digit_reg);
`else
         digit_next = bcd_inc(digit_reg);
`endif
      end
   end

   // Digit state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit_reg <= BCD_MIN;
      end else begin
         digit_reg <= digit_next;
      end
   end

   assign digit = digit_reg;

`ifdef COUNTER_UPDOWN_EN
   assign at_terminal = up ? (digit_reg == BCD_MAX) : (digit_reg == BCD_MIN);
`else
   assign at_terminal = (digit_reg == BCD_MAX);
`endif

endmodule

// File: rtl/bcd_counter_chain.sv
// Cascaded BCD counter, NUM_DIGITS decades (1..8), with enable, synchronous
// preset, registered rollover strobes and 50%-duty divided clocks.
// Optional up/down counting is enabled by defining COUNTER_UPDOWN_EN.
// The carry chain is purely combinational, so all digits update on the same
// edge; roll and clk_div are flops that line up with the count register.
module bcd_counter_chain
   import bcd_counter_pkg::*;
#(
   parameter int NUM_DIGITS = 2
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_val,
`ifdef COUNTER_UPDOWN_EN
   input  logic                    up,
`endif
   output logic [4*NUM_DIGITS-1:0] count,
   output logic [NUM_DIGITS-1:0]   roll,
   output logic [NUM_DIGITS-1:0]   clk_div
);

   logic [NUM_DIGITS-1:0] step;
   logic [NUM_DIGITS-1:0] at_terminal;
   logic [NUM_DIGITS-1:0] roll_reg;
   logic [NUM_DIGITS-1:0] roll_next;
   logic [NUM_DIGITS-1:0] clk_div_reg;
   logic [NUM_DIGITS-1:0] clk_div_next;
   logic                  up_dir;

`ifdef COUNTER_UPDOWN_EN
   assign up_dir = up;
`else
   assign up_dir = 1'b1;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         bcd_digit_t digit_w;
         bcd_digit_t stepped_w;
         bcd_digit_t digit_next_w;

         // Counting is suppressed on load cycles so no roll strobe can follow a preset
         if (gi == 0) begin : g_first
            assign step[gi] = en & ~load;
         end else begin : g_rest
            assign step[gi] = step[gi-1] & at_terminal[gi-1];
         end

         bcd_digit u_digit (
            .clk         (clk),
            .rst         (rst),
            .step        (step[gi]),
`ifdef COUNTER_UPDOWN_EN
            .up          (up_dir),
`endif
            .load        (load),
            .load_digit  (load_val[4*gi +: 4]),
            .digit       (digit_w),
            .at_terminal (at_terminal[gi])
         );

`ifdef COUNTER_UPDOWN_EN
         assign stepped_w = up_dir ? bcd_inc(digit_w) : bcd_dec(digit_w);
`else
         assign stepped_w = bcd_inc(digit_w);
`endif

         // Value the digit will hold after this edge, used to keep clk_div aligned with count
         assign digit_next_w = load     ? bcd_sanitize(load_val[4*gi +: 4]) :
                               step[gi] ? stepped_w : digit_w;

         assign clk_div_next[gi] = (digit_next_w >= DIV_HALF);
         // Digits 0..gi all wrap together exactly when this stage steps while at its terminal value
         assign roll_next[gi]    = step[gi] & at_terminal[gi];
         assign count[4*gi +: 4] = digit_w;
      end
   endgenerate

   // Registered strobe and divided-clock outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         roll_reg    <= '0;
         clk_div_reg <= '0;
      end else begin
         roll_reg    <= roll_next;
         clk_div_reg <= clk_div_next;
      end
   end

   assign roll    = roll_reg;
   assign clk_div = clk_div_reg;

   // up_dir only steers the digit cells in the up/down build
   logic unused_dir;
   assign unused_dir = up_dir;

endmodule

// File: doc/bcd_counter_chain.md
# bcd_counter_chain

Parametrised cascaded BCD (decade) counter with NUM_DIGITS digits, count enable, synchronous load and per-digit divide-by-10^k outputs. It succeeds the fixed two-digit decade counter. It adds arbitrary digit count, gated counting, preset, and registered rollover strobes alongside 50%-duty divided clocks. It sits in the timebase path, feeding display drivers and lower-rate logic.

## Interface
- NUM_DIGITS, 2: number of cascaded BCD digits, 1..8.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; one count step per rising edge with en=1.
- load  in  1  synchronous load; priority over en.
- load_val  in  4*NUM_DIGITS  BCD preset, digit 0 in bits [3:0].
- up  in  1  direction, 1=up, 0=down; present only with COUNTER_UPDOWN_EN.
- count  out  4*NUM_DIGITS  current BCD value, digit i in bits [4i+3:4i].
- roll  out  NUM_DIGITS  roll[i]: 1-cycle strobe, digits 0..i just wrapped.
- clk_div  out  NUM_DIGITS  clk_div[i]: square wave at f(en)/10^(i+1), 50% duty.

## Operation
- Reset values: count=0, roll=0, clk_div=0. Reset applies immediately, mid-count or mid-load.
- Priority per edge: rst > load > en > hold.
- load=1: count <= load_val. Any nibble >9 loads as 0 for that digit only. roll <= 0. clk_div[i] <= (loaded digit i >= 5). Load never generates a roll strobe.
- en=1, up mode:
  - digit 0 increments.
  - digit i increments only when digits 0..i-1 are all 9.
  - digit 9 wraps to 0.
- en=1, down mode:
  - digit 0 decrements.
  - digit i decrements only when digits 0..i-1 are all 0.
  - digit 0 wraps to 9.
- roll[i] is registered. It is 1 in the cycle after an enabled edge on which digits 0..i all wrapped (9→0 up, 0→9 down); otherwise 0. roll[NUM_DIGITS-1] marks full-counter wrap.
- clk_div[i] is registered. It equals 1 while digit i is in 5..9, in both directions.
- en=0: count, clk_div hold; roll <= 0.
- Full-range wrap:
  - up: all-9 → all-0, every roll bit set.
  - down: all-0 → all-9, every roll bit set.
- Direction change takes effect on the next enabled edge. There is no extra latency and no spurious roll.

## Timing
- Latency: count, roll, clk_div all change 1 clk after the qualifying edge. All three are flop outputs, glitch-free.
- roll[i] period: 10^(i+1) enabled cycles; width exactly 1 clk.
- clk_div[i] period: 10^(i+1) enabled cycles; high phase 5·10^i enabled cycles.
- With en tied high, NUM_DIGITS=2: roll[0] every 10 clk, roll[1] every 100 clk.
- Carry chain is combinational across digits within one cycle. No ripple delay between digits.

## Configuration
- COUNTER_UPDOWN_EN defined:
  - up port exists.
  - down counting behaves as above.
- COUNTER_UPDOWN_EN undefined:
  - no up port.
  - counter is up-only.
  - all down-mode logic is absent.

## Structure
- Package bcd_counter_pkg holds:
  - bcd_digit_t (4-bit) type.
  - BCD_MAX=9, BCD_MIN=0, DIV_HALF=5 constants.
  - MAX_DIGITS=8 constant.
- Sub-module bcd_digit: one decade cell.
  - Inputs: clk, rst, step, up, load, load_digit.
  - Outputs: digit, at_terminal.
  - Top generates NUM_DIGITS instances.
  - Top forms step[i] = en & AND(at_terminal[0..i-1]).
  - Top registers roll and clk_div.

## Test plan
All cases use NUM_DIGITS=2 unless stated.
- Reset then en=1 for 100 clk → count walks 00..99→00; roll[0] 10 pulses; roll[1] one pulse, at the cycle count=00; clk_div[1] high exactly 50 clk.
- load_val=8'h97, load=1 then en=1 for 3 clk → count 97,98,99,00; roll=2'b11 only in the cycle showing 00; load cycle produces no roll.
- load_val=8'h5C → count=8'h50, clk_div=2'b10; load and en asserted together → load wins.
- Toggle en 1/0 each clk for 40 clk from 00 → count=20; roll[0] pulses twice; outputs hold during en=0.
- rst asserted mid-count at count=47 between edges → count=00, roll=0, clk_div=0 immediately, before the next clk edge.
- COUNTER_UPDOWN_EN defined, up=0, from 00, en=1 → 99 with roll=2'b11; next 98; switching up=1 at 98 → 99 then 00.
